// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, FSM states, address helpers.
// The STOP state exists only when MISALIGN_TRAP_EN is defined.
package instr_fetch_pkg;

    localparam logic [31:0] RV_NOP  = 32'h0000_0013;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
`ifdef MISALIGN_TRAP_EN
        ,
        S_STOP  = 3'd5
`endif
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/instr_fetch_skid_buf.sv
// One-entry skid buffer that parks a returned instruction while Decode is stalled.
module if_skid_buf
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_clear,
    input  logic [31:0] i_data,
    output logic        o_full,
    output logic [31:0] o_data
);

    logic        r_full;
    logic [31:0] r_data;

    // Clear beats load so a redirect never leaves stale data behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and drives the IF/ID register.
// Define MISALIGN_TRAP_EN to trap misaligned redirect targets instead of forcing word alignment.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = RV_NOP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_if,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    instr_fetch_if.master        imem,
    output logic [31:0]          Instruction_id,
    output logic [31:0]          PC_id,
    output logic                 valid_id,
    output logic                 misalign_id
);

    fetch_state_e r_state;
    fetch_state_e w_nxt;
    logic         r_req;
    logic [31:0]  r_pc;
    logic [31:0]  r_insn;
    logic [31:0]  r_pc_id;
    logic         r_valid;
    logic         r_mis;

    logic         w_pending;
    logic         w_load;
    logic         w_from_skid;
    logic         w_skid_load;
    logic         w_skid_unload;
    logic         w_skid_full;
    logic [31:0]  w_skid_data;
    logic [31:0]  w_redir_pc;

`ifdef MISALIGN_TRAP_EN
    logic         w_misalign;
    assign w_redir_pc = redirect_pc;
    assign w_misalign = is_misaligned(redirect_pc[1:0]);
`else
    assign w_redir_pc = align_word(redirect_pc);
`endif

    if_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (redirect),
        .i_data   (imem.rdata),
        .o_full   (w_skid_full),
        .o_data   (w_skid_data)
    );

    // A response is still owed by memory if one was accepted and has not come back yet.
    always_comb begin
        w_nxt         = r_state;
        w_load        = 1'b0;
        w_from_skid   = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_pending     = (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem.rvalid) ||
                        ((r_state == S_REQ) && imem.ready);
        if (redirect) begin
            w_nxt = w_pending ? S_DRAIN : S_REQ;
`ifdef MISALIGN_TRAP_EN
            if (w_misalign) begin
                w_nxt = S_STOP;
            end
`endif
        end else begin
            case (r_state)
                S_IDLE:  w_nxt = S_REQ;
                S_REQ:   if (imem.ready) w_nxt = S_WAIT;
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (stall_if) begin
                            w_skid_load = 1'b1;
                            w_nxt       = S_HOLD;
                        end else begin
                            w_load = 1'b1;
                            w_nxt  = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_if) begin
                        w_nxt = S_REQ;
                        if (w_skid_full) begin
                            w_load        = 1'b1;
                            w_from_skid   = 1'b1;
                            w_skid_unload = 1'b1;
                        end
                    end
                end
                S_DRAIN: if (imem.rvalid) w_nxt = S_REQ;
                default: w_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_pc    <= RESET_PC;
            r_insn  <= NOP_INSN;
            r_pc_id <= 32'h0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_req   <= (w_nxt == S_REQ);
            if (redirect) begin
                r_pc    <= w_redir_pc;
                r_insn  <= NOP_INSN;
                r_pc_id <= 32'h0;
                r_valid <= 1'b0;
                r_mis   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                // The trap travels down the pipe as a valid NOP tagged with the bad target.
                if (w_misalign) begin
                    r_pc_id <= redirect_pc;
                    r_valid <= 1'b1;
                    r_mis   <= 1'b1;
                end
`endif
            end else if (w_load) begin
                r_insn  <= w_from_skid ? w_skid_data : imem.rdata;
                r_pc_id <= r_pc;
                r_valid <= 1'b1;
                r_pc    <= r_pc + PC_STEP;
            end
        end
    end

    assign imem.req       = r_req;
    assign imem.addr      = r_pc;
    assign Instruction_id = r_insn;
    assign PC_id          = r_pc_id;
    assign valid_id       = r_valid;
    assign misalign_id    = r_mis;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a 1-cycle memory model plus monitors on fetch requests and IF/ID.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_if = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] Instruction_id;
    logic [31:0] PC_id;
    logic        valid_id;
    logic        misalign_id;

    instr_fetch_if imem ();

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSN (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_if       (stall_if),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id),
        .valid_id       (valid_id),
        .misalign_id    (misalign_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [65:0] exp_ifid_q[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00003f37;
            32'h0000_0004: return 32'h00100093;
            32'h0000_0008: return 32'h042f0293;
            32'h0000_000C: return 32'h00208113;
            32'h0000_0040: return 32'h0040006f;
            32'h0000_0044: return 32'h00c00193;
            32'h0000_0080: return 32'h00a00213;
            32'h0000_0084: return 32'h00b00293;
            32'hFFFF_FFFC: return 32'h00000073;
            default:       return 32'hbad00013;
        endcase
    endfunction

    function automatic logic [65:0] ifid(input logic [31:0] i, input logic [31:0] p,
                                         input logic v, input logic m);
        return {i, p, v, m};
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: always ready, answers one cycle after acceptance unless mem_hold delays it.
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        mem_hold = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_acc;
    logic [31:0] m_addr;
    logic [31:0] m_pend_addr = 32'h0;

    assign imem.ready  = 1'b1;
    assign imem.rvalid = m_rvalid;
    assign imem.rdata  = m_rdata;

    always @(posedge clk) begin
        m_acc  = imem.req && imem.ready;
        m_addr = imem.addr;
        if (m_rvalid) m_pend = 1'b0;
        if (m_acc) begin
            m_pend      = 1'b1;
            m_pend_addr = m_addr;
        end
        #1;
        m_rvalid = m_pend && !mem_hold;
        m_rdata  = m_pend ? memfn(m_pend_addr) : 32'h0;
    end

    // Request monitor: every request presented with ready high is accepted at the next edge.
    always @(negedge clk) begin
        if (!reset && imem.req && imem.ready) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL addr_unexpected: got %h expected none", imem.addr);
            end else begin
                chk("fetch_addr", {34'h0, imem.addr}, {34'h0, exp_addr_q.pop_front()});
            end
        end
    end

    // IF/ID monitor: any change of the register contents must match the next expected entry.
    logic [65:0] prev_ifid = {NOP, 32'h0, 1'b0, 1'b0};
    logic [65:0] mon_cur;
    always @(negedge clk) begin
        if (!reset) begin
            mon_cur = {Instruction_id, PC_id, valid_id, misalign_id};
            if (mon_cur !== prev_ifid) begin
                if (exp_ifid_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL ifid_unexpected: got %h expected none", mon_cur);
                end else begin
                    chk("ifid", mon_cur, exp_ifid_q.pop_front());
                end
                prev_ifid = mon_cur;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_insn",  {34'h0, Instruction_id}, {34'h0, NOP});
        chk("rst_pcid",  {34'h0, PC_id}, 66'h0);
        chk("rst_valid", {65'h0, valid_id}, 66'h0);
        chk("rst_mis",   {65'h0, misalign_id}, 66'h0);
        chk("rst_req",   {65'h0, imem.req}, 66'h0);
        chk("rst_addr",  {34'h0, imem.addr}, 66'h0);

        // Straight-line fetch from address 0
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_ifid_q.push_back(ifid(32'h00003f37, 32'h0, 1'b1, 1'b0));
        exp_ifid_q.push_back(ifid(32'h00100093, 32'h4, 1'b1, 1'b0));
        reset = 1'b0;
        step(6);

        // Stall while the word for 0x8 returns
        stall_if = 1'b1;
        exp_ifid_q.push_back(ifid(32'h042f0293, 32'h8, 1'b1, 1'b0));
        exp_addr_q.push_back(32'hC);
        step(2);
        chk("hold_req",  {65'h0, imem.req}, 66'h0);
        chk("hold_insn", {34'h0, Instruction_id}, {34'h0, 32'h00100093});
        chk("hold_pcid", {34'h0, PC_id}, {34'h0, 32'h4});
        step(1);
        stall_if = 1'b0;
        step(1);

        // Redirect to 0x40 while waiting on the 0xC response
        step(1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        exp_ifid_q.push_back(ifid(NOP, 32'h0, 1'b0, 1'b0));
        exp_addr_q.push_back(32'h40);
        exp_ifid_q.push_back(ifid(32'h0040006f, 32'h40, 1'b1, 1'b0));
        step(1);
        redirect = 1'b0;
        step(2);

        // Redirect to 0x80 with stall, response for 0x44 still outstanding
        mem_hold = 1'b1;
        exp_addr_q.push_back(32'h44);
        step(1);
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        stall_if    = 1'b1;
        exp_ifid_q.push_back(ifid(NOP, 32'h0, 1'b0, 1'b0));
        step(1);
        redirect = 1'b0;
        stall_if = 1'b0;
        mem_hold = 1'b0;
        chk("drain_req", {65'h0, imem.req}, 66'h0);
        exp_addr_q.push_back(32'h80);
        exp_ifid_q.push_back(ifid(32'h00a00213, 32'h80, 1'b1, 1'b0));
        step(2);
        chk("drain_valid", {65'h0, valid_id}, 66'h0);
        chk("drain_insn",  {34'h0, Instruction_id}, {34'h0, NOP});
        step(2);

        // Redirect to misaligned 0x42 while the 0x84 request is being accepted
        exp_addr_q.push_back(32'h84);
        redirect    = 1'b1;
        redirect_pc = 32'h42;
`ifdef MISALIGN_TRAP_EN
        exp_ifid_q.push_back(ifid(NOP, 32'h42, 1'b1, 1'b1));
        step(1);
        redirect = 1'b0;
        step(2);
        chk("trap_req",   {65'h0, imem.req}, 66'h0);
        chk("trap_mis",   {65'h0, misalign_id}, 66'h1);
        chk("trap_valid", {65'h0, valid_id}, 66'h1);
        exp_ifid_q.push_back(ifid(NOP, 32'h0, 1'b0, 1'b0));
        exp_addr_q.push_back(32'h40);
        exp_ifid_q.push_back(ifid(32'h0040006f, 32'h40, 1'b1, 1'b0));
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step(1);
        redirect = 1'b0;
        step(2);
`else
        exp_ifid_q.push_back(ifid(NOP, 32'h0, 1'b0, 1'b0));
        exp_addr_q.push_back(32'h40);
        exp_ifid_q.push_back(ifid(32'h0040006f, 32'h40, 1'b1, 1'b0));
        step(1);
        redirect = 1'b0;
        chk("align_addr", {34'h0, imem.addr}, {34'h0, 32'h40});
        chk("align_mis",  {65'h0, misalign_id}, 66'h0);
        step(3);
`endif

        // Redirect to the last word, PC wraps to 0
        exp_addr_q.push_back(32'h44);
        exp_ifid_q.push_back(ifid(NOP, 32'h0, 1'b0, 1'b0));
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_ifid_q.push_back(ifid(32'h00000073, 32'hFFFF_FFFC, 1'b1, 1'b0));
        exp_addr_q.push_back(32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect = 1'b0;
        step(4);

        // Asynchronous reset pulse while the response for 0x0 is on the bus
        exp_ifid_q.push_back(ifid(NOP, 32'h0, 1'b0, 1'b0));
        reset = 1'b1;
        #1;
        chk("areset_insn",  {34'h0, Instruction_id}, {34'h0, NOP});
        chk("areset_valid", {65'h0, valid_id}, 66'h0);
        chk("areset_req",   {65'h0, imem.req}, 66'h0);
        reset = 1'b0;
        exp_addr_q.push_back(32'h0);
        exp_ifid_q.push_back(ifid(32'h00003f37, 32'h0, 1'b1, 1'b0));
        exp_addr_q.push_back(32'h4);
        step(1);
        chk("late_rvalid_valid", {65'h0, valid_id}, 66'h0);
        step(3);

        chk("addr_q_drained", {34'h0, 32'(exp_addr_q.size())}, 66'h0);
        chk("ifid_q_drained", {34'h0, 32'(exp_ifid_q.size())}, 66'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
